// File: rtl/sum_arbiter.sv
// Round-robin sequencer that shares one external registered adder among NREQ requesters.
// Each operation takes 4 cycles: it grants a requester, lets the adder register, captures the sum, then pulses done.
module sum_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 32,
  parameter int CNTW = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NREQ-1:0]   req_i,
  input  logic [NREQ*W-1:0] op_a_i,
  input  logic [NREQ*W-1:0] op_b_i,
  output logic [NREQ-1:0]   grant_o,
  output logic [NREQ-1:0]   done_o,
  output logic [W-1:0]      result_o,
  output logic              busy_o,
  output logic [W-1:0]      add_a_o,
  output logic [W-1:0]      add_b_o,
  input  logic [W-1:0]      add_sum_i,
  output logic [CNTW-1:0]   op_count_o
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

  state_e            state_q;
  logic [PW-1:0]     ptr_q;
  logic [NREQ-1:0]   grant_q, done_q;
  logic [W-1:0]      result_q, add_a_q, add_b_q;
  logic [CNTW-1:0]   cnt_q;

  logic [PW-1:0]     win_d, ptr_d;
  logic              found_d;
  int                idx;

  // First requester at or after ptr, wrapping around
  always_comb begin
    win_d   = '0;
    found_d = 1'b0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!found_d && req_i[idx]) begin
        found_d = 1'b1;
        win_d   = PW'(idx);
      end
    end
    ptr_d = (win_d == PW'(NREQ-1)) ? '0 : win_d + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      grant_q  <= '0;
      done_q   <= '0;
      result_q <= '0;
      add_a_q  <= '0;
      add_b_q  <= '0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE: if (found_d) begin
          grant_q <= NREQ'(1) << win_d;
          add_a_q <= op_a_i[win_d*W +: W];
          add_b_q <= op_b_i[win_d*W +: W];
          ptr_q   <= ptr_d;
          state_q <= ISSUE;
        end
        ISSUE: state_q <= WAIT;
        WAIT: begin
          // adder output reflects operands registered at the end of ISSUE
          result_q <= add_sum_i;
          done_q   <= grant_q;
          cnt_q    <= cnt_q + 1'b1;
          state_q  <= DONE;
        end
        DONE: begin
          done_q  <= '0;
          grant_q <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant_o    = grant_q;
  assign done_o     = done_q;
  assign result_o   = result_q;
  assign busy_o     = (state_q != IDLE);
  assign add_a_o    = add_a_q;
  assign add_b_o    = add_b_q;
  assign op_count_o = cnt_q;
endmodule

// File: doc/sum_arbiter.md
Name: sum_arbiter

Overview:
Round-robin arbiter and sequencer that shares one registered 32-bit adder (1-cycle latency, no reset, no carry out) among NREQ requesters in the TRNG post-processing path. It selects one pending requester and drives that requester's operands to the adder. It captures the sum one cycle later and returns it with a one-hot done pulse. It also keeps a count of completed operations for debug readout.

Parameters:
NREQ, 4, number of requesters (2..8)
W, 32, operand/result width; must match adder width
CNTW, 16, width of completed-operation counter

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
req  input  NREQ  per-requester request level; bit i belongs to requester i
op_a  input  NREQ*W  packed operand A; requester i uses bits [i*W +: W]
op_b  input  NREQ*W  packed operand B, same packing
grant  output  NREQ  one-hot registered grant of the current owner; 0 when idle
done  output  NREQ  one-hot, one-cycle pulse; result valid for that requester
result  output  W  last completed sum; held until the next completion
busy  output  1  high in any state other than IDLE
add_a  output  W  registered operand to adder sig_0
add_b  output  W  registered operand to adder sig_1
add_sum  input  W  adder sum_0, valid one cycle after add_a/add_b are stable
op_count  output  CNTW  number of completed operations, wraps modulo 2^CNTW

Behaviour:
- Reset values (rst high at an edge): state=IDLE, grant=0, done=0, result=0, add_a=0, add_b=0, op_count=0, rr pointer=0, busy=0. Reset overrides any in-flight operation. No done is produced for an aborted operation.
- FSM states: IDLE, ISSUE, WAIT, DONE. One operation occupies 4 cycles. At most one operation is outstanding.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise pick a winner by round-robin. Scan indices ptr, ptr+1, … modulo NREQ and take the first index with req set.
  - At that edge: grant<=onehot(winner), add_a<=op_a[winner], add_b<=op_b[winner], ptr<=(winner+1) mod NREQ, next state ISSUE.
- ISSUE: add_a/add_b are stable. The adder registers them at the end of this cycle. Next state WAIT.
- WAIT: add_sum is valid. At this edge: result<=add_sum, done<=grant, op_count<=op_count+1, next state DONE.
- DONE: done is high for exactly this cycle. At this edge: done<=0, grant<=0, next state IDLE.
- Latency: req sampled in IDLE at cycle n gives grant visible in n+1 and done/result visible in n+3. The next arbitration happens at the end of cycle n+4. Throughput is 1 operation per 4 cycles.
- Arithmetic: result = (op_a + op_b) mod 2^W. Overflow is silently discarded and there is no carry indication.
- Operand capture: operands are captured only in IDLE at the grant edge. Requesters may change op_a/op_b after grant rises without affecting the in-flight sum.
- Requester protocol: hold req high until done. Drop req on the edge at which the done bit is high; req must be low from cycle n+4.
- A req kept high after done is treated as a new request. It still yields to any other pending requester because ptr has moved past that requester.
- req is ignored outside IDLE. Dropping req mid-operation does not abort it: done still pulses and result still updates.
- Simultaneous requests: exactly one grant. Since ptr resets to 0, the first service order after reset with all requesting is 0,1,…,NREQ-1, then it repeats.
- A single requester that is the only one requesting is re-served every 4 cycles.
- grant and done are never multi-hot. done is nonzero only in state DONE. busy = (state != IDLE).
- op_count increments once per completion and wraps from 2^CNTW-1 to 0.

Test Plan:
- Reset, then req=0001 with op_a[0]=0x0000_0005, op_b[0]=0x0000_0007 in cycle n -> grant=0001 in n+1, add_a=5, add_b=7; done=0001 and result=0x0000_000C in n+3; op_count=1; busy low in n+4.
- Overflow: op_a=0xFFFF_FFFF, op_b=0x0000_0002 on requester 2 -> result=0x0000_0001, done=0100.
- req=1111 held continuously, each requester given distinct operands (A=i, B=0x100) -> done order 0001,0010,0100,1000,0001 at 4-cycle spacing; results 0x100,0x101,0x102,0x103; grant always one-hot.
- Requester 1 drops req and changes op_a in the cycle after grant -> done=0010 still pulses and result equals the sum of the originally captured operands.
- rst asserted during WAIT -> next cycle all outputs 0 and state IDLE, no done pulse. A subsequent req=1010 grants requester 1 first (ptr=0).
- op_count preset by running 2^CNTW-1 operations (or with CNTW=4, 15 operations) -> the next completion wraps op_count to 0.
